// File: rtl/blink_pkg.sv
// Shared constants for the LED pattern scheduler: state encoding, LED patterns, default divider widths.
// No logic, no latency, no backpressure.
package blink_pkg;

  localparam int CNTW_DEF = 27;
  localparam int DBW_DEF  = 20;

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [2:0] LED_S0 = 3'b100;
  localparam logic [2:0] LED_S1 = 3'b010;
  localparam logic [2:0] LED_S2 = 3'b001;
  localparam logic [2:0] LED_S3 = 3'b111;
  localparam logic [2:0] LED_S4 = 3'b000;

  function automatic logic [2:0] led_pat(input logic [2:0] step);
    case (step)
      3'd0:    return LED_S0;
      3'd1:    return LED_S1;
      3'd2:    return LED_S2;
      3'd3:    return LED_S3;
      default: return LED_S4;
    endcase
  endfunction

endpackage

// File: rtl/blink_sched_if.sv
// Board-side bundle for blink_sched: raw buttons in, pattern/status out.
// Pure wiring, no latency, no backpressure.
interface blink_sched_if;
  logic [1:0] BTN;
  logic [2:0] LED;
  logic [1:0] SPEED;
  logic       RUNNING;

  modport master (output BTN, input LED, input SPEED, input RUNNING);
  modport slave  (input BTN, output LED, output SPEED, output RUNNING);
endinterface

// File: rtl/btn_pulse.sv
// One button: 2-flop synchronizer, sampler on shared enable, rising-sample to one-cycle pulse.
// Pulse is combinational on the enable cycle, 2 cycles + sample window after the press; no backpressure.
module btn_pulse (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  input  logic smp_en,
  output logic pls
);

  logic sync1, sync2, smp_prev, armed;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      smp_prev <= 1'b0;
      armed    <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      // First sample after reset only arms, so a button held through reset is ignored.
      if (smp_en) begin
        smp_prev <= sync2;
        armed    <= 1'b1;
      end
    end
  end

  assign pls = smp_en & armed & sync2 & ~smp_prev;

endmodule

// File: rtl/blink_sched.sv
// Button-driven STOP/RUN/PAUSE scheduler stepping a 5-entry LED pattern at 2^(CNTW-SPEED) cycles per step.
// State changes one edge after a button pulse, LED decodes combinationally; no backpressure.
module blink_sched
  import blink_pkg::*;
#(
  parameter int CNTW = CNTW_DEF,
  parameter int DBW  = DBW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  blink_sched_if.slave  io
);

  logic [DBW-1:0]  smp_cnt;
  logic            smp_en;
  logic            spd_pls, run_pls;
  logic [1:0]      state, speed;
  logic [CNTW-1:0] div, tick_mask;
  logic [2:0]      step;
  logic            tick;

  assign smp_en = &smp_cnt;

  btn_pulse u_spd (.CLK(CLK), .RST(RST), .btn(io.BTN[0]), .smp_en(smp_en), .pls(spd_pls));
  btn_pulse u_run (.CLK(CLK), .RST(RST), .btn(io.BTN[1]), .smp_en(smp_en), .pls(run_pls));

  // Each speed step halves the tick period by dropping one bit from the compare.
  assign tick_mask = {CNTW{1'b1}} >> speed;
  assign tick      = (state == ST_RUN) && ((div & tick_mask) == tick_mask);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp_cnt <= '0;
      state   <= ST_STOP;
      speed   <= 2'd0;
      div     <= '0;
      step    <= 3'd0;
    end else begin
      smp_cnt <= smp_cnt + DBW'(1);
      if (spd_pls && run_pls) begin
        state <= ST_STOP;
        div   <= '0;
        step  <= 3'd0;
      end else begin
        case (state)
          ST_RUN:   div <= div + CNTW'(1);
          ST_PAUSE: div <= div;
          default:  div <= '0;
        endcase
        if (spd_pls) begin
          speed <= speed + 2'd1;
          div   <= '0;
        end
        if (tick)
          step <= (step == 3'd4) ? 3'd0 : step + 3'd1;
        if (run_pls)
          state <= (state == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
    end
  end

  assign io.LED     = (state == ST_STOP) ? LED_S4 : led_pat(step);
  assign io.SPEED   = speed;
  assign io.RUNNING = (state == ST_RUN);

endmodule

// File: tb/tb_blink_sched.sv
// Bench for blink_sched (CNTW=6, DBW=2): behavioural model checked every cycle, directed scenarios, random button traffic.
`timescale 1ns/1ps
module tb_blink_sched;

  localparam int CW = 6;
  localparam int DW = 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  blink_sched_if bif();

  blink_sched #(.CNTW(CW), .DBW(DW)) dut (.CLK(CLK), .RST(RST), .io(bif.slave));

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] pat [0:4] = '{3'b100, 3'b010, 3'b001, 3'b111, 3'b000};

  // Model state: 0 = STOP, 1 = RUN, 2 = PAUSE.
  int         m_st = 0, m_spd = 0, m_div = 0, m_step = 0, m_scnt = 0;
  logic [1:0] m_b1 = 2'b00, m_b2 = 2'b00, m_prev = 2'b00, m_lvl;
  bit         m_arm = 0, m_en, m_ps, m_pr, m_tk;
  int         m_per, m_nd;

  initial forever begin
    @(posedge CLK or negedge RST);
    if (!RST) begin
      m_st = 0; m_spd = 0; m_div = 0; m_step = 0; m_scnt = 0;
      m_b1 = 2'b00; m_b2 = 2'b00; m_prev = 2'b00; m_arm = 0;
    end else begin
      m_en  = (m_scnt == (1 << DW) - 1);
      m_lvl = m_b2;
      m_ps  = m_en && m_arm && m_lvl[0] && !m_prev[0];
      m_pr  = m_en && m_arm && m_lvl[1] && !m_prev[1];
      m_per = 1 << (CW - m_spd);
      m_tk  = (m_st == 1) && ((m_div % m_per) == m_per - 1);
      if (m_en) begin
        m_prev = m_lvl;
        m_arm  = 1;
      end
      m_b2   = m_b1;
      m_b1   = bif.BTN;
      m_scnt = (m_scnt + 1) % (1 << DW);
      if (m_ps && m_pr) begin
        m_st = 0; m_step = 0; m_div = 0;
      end else begin
        m_nd = (m_st == 1) ? (m_div + 1) % (1 << CW) : (m_st == 2) ? m_div : 0;
        if (m_ps) begin
          m_spd = (m_spd + 1) % 4;
          m_nd  = 0;
        end
        if (m_tk) m_step = (m_step + 1) % 5;
        if (m_pr) m_st = (m_st == 1) ? 2 : 1;
        m_div = m_nd;
      end
    end
  end

  logic [2:0] e_led;
  initial forever begin
    @(negedge CLK);
    e_led = (m_st == 0) ? 3'b000 : pat[m_step];
    vectors++;
    if (bif.LED !== e_led || bif.SPEED !== 2'(m_spd) || bif.RUNNING !== (m_st == 1)) begin
      miscompares++;
      $display("FAIL cycle_check @%0t: LED=%b SPEED=%0d RUNNING=%b, model LED=%b SPEED=%0d RUNNING=%b",
               $time, bif.LED, bif.SPEED, bif.RUNNING, e_led, m_spd, (m_st == 1));
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", nm, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic int getsig(input int which);
    case (which)
      0:       return int'(bif.RUNNING);
      1:       return int'(bif.SPEED);
      default: return int'(bif.LED);
    endcase
  endfunction

  task automatic wait_sig(input string nm, input int which, input int val, input int lim);
    bit hit = 0;
    for (int i = 0; i < lim && !hit; i++) begin
      @(negedge CLK);
      if (getsig(which) == val) hit = 1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d within %0d cycles", nm, getsig(which), val, lim);
    end
  endtask

  longint t0, t1, t2;
  int     rem, idx;
  logic [2:0] l0;

  initial begin
    bif.BTN = 2'b00;
    cyc(3);
    chk("reset_led", 8'(bif.LED), 8'd0);
    chk("reset_speed", 8'(bif.SPEED), 8'd0);
    chk("reset_running", 8'(bif.RUNNING), 8'd0);
    #2 RST = 1'b1;

    cyc(200);
    chk("idle_led", 8'(bif.LED), 8'd0);
    chk("idle_speed", 8'(bif.SPEED), 8'd0);
    chk("idle_running", 8'(bif.RUNNING), 8'd0);

    // Start and walk one full pattern at speed 0 (64 cycles per step).
    bif.BTN = 2'b10;
    wait_sig("run_start", 0, 1, 20);
    bif.BTN = 2'b00;
    chk("run_first_led", 8'(bif.LED), 8'b100);
    for (int k = 1; k <= 5; k++) begin
      cyc(63);
      chk("step_hold", 8'(bif.LED), 8'(pat[k-1]));
      cyc(1);
      chk("step_adv", 8'(bif.LED), 8'(pat[k % 5]));
    end

    // Three speed presses give an 8-cycle step.
    for (int i = 1; i <= 3; i++) begin
      bif.BTN = 2'b01;
      wait_sig("speed_up", 1, i, 20);
      bif.BTN = 2'b00;
      if (i < 3) cyc(10);
    end
    l0 = bif.LED;
    idx = 0;
    for (int j = 0; j < 5; j++) if (pat[j] == l0) idx = j;
    cyc(7);
    chk("fast_hold", 8'(bif.LED), 8'(l0));
    cyc(1);
    chk("fast_step1", 8'(bif.LED), 8'(pat[(idx + 1) % 5]));
    cyc(8);
    chk("fast_step2", 8'(bif.LED), 8'(pat[(idx + 2) % 5]));
    cyc(10);
    bif.BTN = 2'b01;
    wait_sig("speed_wrap", 1, 0, 20);
    bif.BTN = 2'b00;
    cyc(10);

    // Pause at step 2, resume, expect the remainder of the 64-cycle step.
    wait_sig("reach_step2", 2, 1, 400);
    t0 = $time;
    bif.BTN = 2'b10;
    wait_sig("pause", 0, 0, 20);
    t1 = $time;
    bif.BTN = 2'b00;
    chk("pause_led", 8'(bif.LED), 8'b001);
    cyc(500);
    chk("pause_hold", 8'(bif.LED), 8'b001);
    bif.BTN = 2'b10;
    wait_sig("resume", 0, 1, 20);
    t2 = $time;
    bif.BTN = 2'b00;
    rem = 64 - int'((t1 - t0) / 10);
    cyc(rem - 1);
    chk("resume_hold", 8'(bif.LED), 8'b001);
    cyc(1);
    chk("resume_step3", 8'(bif.LED), 8'b111);
    cyc(10);

    // Both buttons in PAUSE force STOP with SPEED kept.
    bif.BTN = 2'b01;
    wait_sig("speed_one", 1, 1, 20);
    bif.BTN = 2'b00;
    cyc(10);
    bif.BTN = 2'b10;
    wait_sig("pause2", 0, 0, 20);
    bif.BTN = 2'b00;
    cyc(10);
    bif.BTN = 2'b11;
    cyc(12);
    bif.BTN = 2'b00;
    chk("both_led", 8'(bif.LED), 8'd0);
    chk("both_speed", 8'(bif.SPEED), 8'd1);
    chk("both_running", 8'(bif.RUNNING), 8'd0);
    cyc(10);
    bif.BTN = 2'b10;
    wait_sig("restart", 0, 1, 20);
    bif.BTN = 2'b00;
    chk("restart_led", 8'(bif.LED), 8'b100);
    cyc(10);

    // Asynchronous reset mid-RUN.
    #2 RST = 1'b0;
    #1;
    chk("async_led", 8'(bif.LED), 8'd0);
    chk("async_speed", 8'(bif.SPEED), 8'd0);
    chk("async_running", 8'(bif.RUNNING), 8'd0);
    bif.BTN = 2'b10;
    cyc(3);
    #2 RST = 1'b1;

    // RUN held through reset release is ignored until re-pressed.
    cyc(50);
    chk("held_running", 8'(bif.RUNNING), 8'd0);
    bif.BTN = 2'b00;
    cyc(10);
    bif.BTN = 2'b10;
    wait_sig("repress", 0, 1, 20);
    bif.BTN = 2'b00;
    cyc(10);

    // Random button traffic with occasional resets.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        #2 RST = 1'b0;
        cyc(2);
        #2 RST = 1'b1;
        cyc(1);
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3: bif.BTN = 2'b00;
        4, 5, 6:    bif.BTN = 2'b01;
        7, 8:       bif.BTN = 2'b10;
        default:    bif.BTN = 2'b11;
      endcase
      cyc($urandom_range(1, 14));
    end
    bif.BTN = 2'b00;
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
